ad4003_acq_scheduler: RTL and testbench

//  Mode sequencer for one AD4003 deserializer port; drives its rst/force_read/force_write controls.

---
 rtl/ad4003_acq_scheduler.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ad4003_acq_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad4003_acq_scheduler.sv
// Mode sequencer for one AD4003 deserializer port: reset hold, config write, verify, turbo run.
// Optional config read-back during RUN is built when AD4003_READBACK_EN is defined.
module ad4003_acq_scheduler #(
    parameter int unsigned FRAME_LEN   = 41,
    parameter int unsigned INIT_FRAMES = 2,
    parameter int unsigned VERIFY_FRM  = 2,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [15:0] EXP_CFG     = 16'h0002
) (
    input  logic        adc_spi_clk,
    input  logic        rst_n,
    input  logic        acq_start,
    input  logic        acq_stop,
    input  logic [31:0] sample_limit,
    input  logic        cfg_req,
    input  logic [15:0] cfg_rdata,
    input  logic        cfg_rvalid,
    output logic        des_rst,
    output logic        des_force_read,
    output logic        des_force_write,
    output logic        acq_active,
    output logic [31:0] sample_cnt,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic [15:0] cfg_word,
    output logic        err
);

    localparam int unsigned FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FCW-1:0] FC_LAST     = FCW'(FRAME_LEN - 1);
    localparam logic [7:0]     INIT_LAST   = 8'(INIT_FRAMES - 1);
    localparam logic [7:0]     VERIFY_LAST = 8'(VERIFY_FRM - 1);
    localparam logic [7:0]     RDBK_LAST   = 8'd1;
    localparam logic [7:0]     RETRY_MAX   = 8'(MAX_RETRY);

`ifdef AD4003_READBACK_EN
    localparam logic RDBK_EN = 1'b1;
`else
    localparam logic RDBK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_RDBK   = 3'd5
    } state_t;

    function automatic logic cfg_ok(input logic [15:0] word);
        return (word[7:0] == EXP_CFG[7:0]);
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [FCW-1:0] frame_cnt_r;
    logic [7:0]     phase_r;
    logic [7:0]     phase_nxt_s;
    logic [7:0]     retry_r;
    logic [7:0]     retry_nxt_s;
    logic           start_pend_r;
    logic           stop_pend_r;
    logic           cfg_pend_r;
    logic [31:0]    limit_r;
    logic [15:0]    cap_word_r;
    logic           cap_seen_r;

    logic           fb_s;
    logic           start_eff_s;
    logic           stop_eff_s;
    logic           cfg_eff_s;
    logic [15:0]    cap_word_s;
    logic           cap_seen_s;
    logic           verify_ok_s;
    logic           limit_hit_s;
    logic [31:0]    cnt_inc_s;
    logic           err_set_s;
    logic           run_begin_s;
    logic           rdbk_done_s;

    // Frame boundary, effective pending requests and capture including this cycle's strobe
    always_comb begin
        fb_s        = (frame_cnt_r == FC_LAST);
        start_eff_s = start_pend_r | acq_start;
        stop_eff_s  = stop_pend_r | acq_stop;
        cfg_eff_s   = cfg_pend_r | (cfg_req & RDBK_EN);
        if (cfg_rvalid) begin
            cap_word_s = cfg_rdata;
        end else begin
            cap_word_s = cap_word_r;
        end
        cap_seen_s  = cap_seen_r | cfg_rvalid;
        verify_ok_s = cap_seen_s & cfg_ok(cap_word_s);
        limit_hit_s = (limit_r != 32'd0) && (sample_cnt == (limit_r - 32'd1));
        if (sample_cnt == 32'hFFFF_FFFF) begin
            cnt_inc_s = sample_cnt;
        end else begin
            cnt_inc_s = sample_cnt + 32'd1;
        end
    end

    // Next-state decode; the state only moves on a frame boundary
    always_comb begin
        state_nxt_s = state_r;
        retry_nxt_s = retry_r;
        err_set_s   = 1'b0;
        if (fb_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (stop_eff_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (start_eff_s) begin
                        state_nxt_s = ST_INIT;
                        retry_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_INIT: begin
                    if (stop_eff_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (phase_r == INIT_LAST) begin
                        state_nxt_s = ST_VERIFY;
                    end else begin
                        state_nxt_s = ST_INIT;
                    end
                end
                ST_VERIFY: begin
                    if (stop_eff_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (phase_r == VERIFY_LAST) begin
                        if (verify_ok_s) begin
                            state_nxt_s = ST_RUN;
                        end else if (retry_r < RETRY_MAX) begin
                            state_nxt_s = ST_INIT;
                            retry_nxt_s = retry_r + 8'd1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            err_set_s   = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_VERIFY;
                    end
                end
                ST_RUN: begin
                    if (stop_eff_s || limit_hit_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else if (cfg_eff_s) begin
                        state_nxt_s = ST_RDBK;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_RDBK: begin
                    if (stop_eff_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else if (phase_r == RDBK_LAST) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_RDBK;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Frames-in-state counter restarts whenever the state changes
    always_comb begin
        phase_nxt_s = phase_r;
        if (fb_s) begin
            if (state_nxt_s != state_r) begin
                phase_nxt_s = 8'd0;
            end else begin
                phase_nxt_s = phase_r + 8'd1;
            end
        end else begin
            phase_nxt_s = phase_r;
        end
        run_begin_s = fb_s && (state_r == ST_IDLE) && (state_nxt_s == ST_INIT);
        rdbk_done_s = fb_s && (state_r == ST_RDBK) && (state_nxt_s == ST_RUN);
    end

    // Sequencer state, request flags, captures and registered outputs
    always_ff @(posedge adc_spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            frame_cnt_r     <= '0;
            phase_r         <= 8'd0;
            retry_r         <= 8'd0;
            start_pend_r    <= 1'b0;
            stop_pend_r     <= 1'b0;
            cfg_pend_r      <= 1'b0;
            limit_r         <= 32'd0;
            cap_word_r      <= 16'd0;
            cap_seen_r      <= 1'b0;
            des_rst         <= 1'b1;
            des_force_read  <= 1'b0;
            des_force_write <= 1'b0;
            acq_active      <= 1'b0;
            sample_cnt      <= 32'd0;
            cfg_busy        <= 1'b0;
            cfg_done        <= 1'b0;
            cfg_word        <= 16'd0;
            err             <= 1'b0;
        end else begin
            if (fb_s) begin
                frame_cnt_r <= '0;
            end else begin
                frame_cnt_r <= frame_cnt_r + FCW'(1);
            end

            // Requests are consumed (or dropped) at every frame boundary
            if (fb_s) begin
                start_pend_r <= 1'b0;
                stop_pend_r  <= 1'b0;
                cfg_pend_r   <= 1'b0;
            end else begin
                start_pend_r <= start_pend_r | acq_start;
                stop_pend_r  <= stop_pend_r | acq_stop;
                cfg_pend_r   <= cfg_pend_r | (cfg_req & RDBK_EN);
            end

            state_r <= state_nxt_s;
            phase_r <= phase_nxt_s;
            retry_r <= retry_nxt_s;

            if (acq_start && (state_r == ST_IDLE)) begin
                limit_r <= sample_limit;
            end else begin
                limit_r <= limit_r;
            end

            if ((state_r != ST_VERIFY) && (state_r != ST_RDBK)) begin
                cap_seen_r <= 1'b0;
                cap_word_r <= cap_word_r;
            end else begin
                cap_seen_r <= cap_seen_s;
                cap_word_r <= cap_word_s;
            end

            if (run_begin_s) begin
                sample_cnt <= 32'd0;
            end else if (fb_s && (state_r == ST_RUN)) begin
                sample_cnt <= cnt_inc_s;
            end else begin
                sample_cnt <= sample_cnt;
            end

            if (run_begin_s) begin
                err <= 1'b0;
            end else if (err_set_s) begin
                err <= 1'b1;
            end else begin
                err <= err;
            end

            cfg_done <= rdbk_done_s;
            if (rdbk_done_s && cap_seen_s) begin
                cfg_word <= cap_word_s;
            end else begin
                cfg_word <= cfg_word;
            end

            des_rst         <= (state_nxt_s == ST_IDLE);
            des_force_read  <= (state_nxt_s == ST_VERIFY) || (state_nxt_s == ST_RDBK);
            des_force_write <= (state_nxt_s == ST_INIT);
            acq_active      <= (state_nxt_s == ST_RUN);
            cfg_busy        <= (state_nxt_s == ST_RDBK);
        end
    end

endmodule

// File: tb/tb_ad4003_acq_scheduler.sv
// Scoreboard bench for ad4003_acq_scheduler: expected output changes (edge, outputs) are queued
// by the stimulus and a monitor compares every observed output change against the queue head.
module tb_ad4003_acq_scheduler;

    logic        adc_spi_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        acq_start = 1'b0;
    logic        acq_stop = 1'b0;
    logic [31:0] sample_limit = 32'd0;
    logic        cfg_req = 1'b0;
    logic [15:0] cfg_rdata = 16'd0;
    logic        cfg_rvalid = 1'b0;
    logic        des_rst;
    logic        des_force_read;
    logic        des_force_write;
    logic        acq_active;
    logic [31:0] sample_cnt;
    logic        cfg_busy;
    logic        cfg_done;
    logic [15:0] cfg_word;
    logic        err;

    // {des_rst, force_read, force_write, acq_active, cfg_busy, cfg_done, err}
    localparam logic [6:0] O_IDLE  = 7'b1000000;
    localparam logic [6:0] O_ERR   = 7'b1000001;
    localparam logic [6:0] O_INIT  = 7'b0010000;
    localparam logic [6:0] O_VER   = 7'b0100000;
    localparam logic [6:0] O_RUN   = 7'b0001000;
    localparam logic [6:0] O_DRAIN = 7'b0000000;
    localparam logic [6:0] O_RDBK  = 7'b0100100;
    localparam logic [6:0] O_DONE  = 7'b0001010;

    typedef struct {
        int          e;
        logic [6:0]  o;
        logic [31:0] c;
        logic [15:0] w;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    ad4003_acq_scheduler dut (
        .adc_spi_clk     (adc_spi_clk),
        .rst_n           (rst_n),
        .acq_start       (acq_start),
        .acq_stop        (acq_stop),
        .sample_limit    (sample_limit),
        .cfg_req         (cfg_req),
        .cfg_rdata       (cfg_rdata),
        .cfg_rvalid      (cfg_rvalid),
        .des_rst         (des_rst),
        .des_force_read  (des_force_read),
        .des_force_write (des_force_write),
        .acq_active      (acq_active),
        .sample_cnt      (sample_cnt),
        .cfg_busy        (cfg_busy),
        .cfg_done        (cfg_done),
        .cfg_word        (cfg_word),
        .err             (err)
    );

    always #5 adc_spi_clk = ~adc_spi_clk;

    // Posedges since reset release; frame boundaries fall on multiples of 41
    always @(posedge adc_spi_clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    function automatic int fb_after(input int p);
        return ((p + 40) / 41) * 41;
    endfunction

    task automatic ex(input int e, input logic [6:0] o, input logic [31:0] c, input logic [15:0] w);
        exp_t x;
        x.e = e; x.o = o; x.c = c; x.w = w;
        q.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic goto(input int e);
        while (edge_n < e) @(negedge adc_spi_clk);
    endtask

    task automatic pulse_start(input logic [31:0] lim, output int t);
        sample_limit = lim;
        acq_start = 1'b1;
        t = fb_after(edge_n + 1);
        @(negedge adc_spi_clk);
        acq_start = 1'b0;
    endtask

    task automatic pulse_stop();
        acq_stop = 1'b1;
        @(negedge adc_spi_clk);
        acq_stop = 1'b0;
    endtask

    task automatic pulse_cfg();
        cfg_req = 1'b1;
        @(negedge adc_spi_clk);
        cfg_req = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] w);
        cfg_rdata = w;
        cfg_rvalid = 1'b1;
        @(negedge adc_spi_clk);
        cfg_rvalid = 1'b0;
        cfg_rdata = 16'h0000;
    endtask

    task automatic drain(input int lim);
        while (q.size() != 0 && edge_n < lim) @(negedge adc_spi_clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d next_edge=%0d now=%0d", q.size(), q[0].e, edge_n);
            q.delete();
        end
    endtask

    // Monitor: every change of the observable outputs must match the queue head
    initial begin
        logic [6:0]  cur;
        logic [6:0]  prev;
        logic [31:0] pc;
        logic [15:0] pw;
        exp_t        x;
        prev = O_IDLE;
        pc = 32'd0;
        pw = 16'd0;
        forever begin
            @(negedge adc_spi_clk);
            cur = {des_rst, des_force_read, des_force_write, acq_active, cfg_busy, cfg_done, err};
            if (cur !== prev || sample_cnt !== pc || cfg_word !== pw) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change edge=%0d outs=%b cnt=%0d word=%h", edge_n, cur, sample_cnt, cfg_word);
                end else begin
                    x = q.pop_front();
                    if (x.e != edge_n || cur !== x.o || sample_cnt !== x.c || cfg_word !== x.w) begin
                        errors++;
                        $display("FAIL trace got edge=%0d outs=%b cnt=%0d word=%h want edge=%0d outs=%b cnt=%0d word=%h",
                                 edge_n, cur, sample_cnt, cfg_word, x.e, x.o, x.c, x.w);
                    end
                end
            end
            prev = cur;
            pc = sample_cnt;
            pw = cfg_word;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog edge=%0d", edge_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int r;
        logic [15:0] wexp;
        wexp = 16'h0000;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge adc_spi_clk);
        #2 rst_n = 1'b1;
        @(negedge adc_spi_clk);
        chk("reset_state", {9'd0, des_rst, des_force_read, des_force_write, acq_active, cfg_busy, cfg_done, err,
                            sample_cnt, cfg_word}, {9'd0, O_IDLE, 32'd0, 16'd0});

        // 1: limited run of 4 samples with a good verify word
        goto(4);
        pulse_start(32'd4, t);
        r = t + 164;
        ex(t, O_INIT, 32'd0, 16'd0);
        ex(t + 82, O_VER, 32'd0, 16'd0);
        ex(r, O_RUN, 32'd0, 16'd0);
        ex(r + 41, O_RUN, 32'd1, 16'd0);
        ex(r + 82, O_RUN, 32'd2, 16'd0);
        ex(r + 123, O_RUN, 32'd3, 16'd0);
        ex(r + 164, O_DRAIN, 32'd4, 16'd0);
        ex(r + 205, O_IDLE, 32'd4, 16'd0);
        goto(t + 90);
        strobe(16'h0002);
        drain(r + 240);

        // 2: verify word always bad -> four INIT/VERIFY passes then err
        pulse_start(32'd4, t);
        for (int i = 0; i < 4; i++) begin
            ex(t + 164 * i, O_INIT, 32'd0, 16'd0);
            ex(t + 164 * i + 82, O_VER, 32'd0, 16'd0);
        end
        ex(t + 656, O_ERR, 32'd0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            goto(t + 164 * i + 90);
            strobe(16'h0000);
        end
        drain(t + 700);

        // 3: continuous run, ignored start in RUN, stop mid-frame 10
        pulse_start(32'd0, t);
        r = t + 164;
        ex(t, O_INIT, 32'd0, 16'd0);
        ex(t + 82, O_VER, 32'd0, 16'd0);
        for (int k = 0; k <= 10; k++) ex(r + 41 * k, O_RUN, 32'(k), 16'd0);
        ex(r + 451, O_DRAIN, 32'd11, 16'd0);
        ex(r + 492, O_IDLE, 32'd11, 16'd0);
        goto(t + 90);
        strobe(16'h0002);
        goto(r + 130);
        pulse_start(32'd2, t);
        goto(r + 430);
        pulse_stop();
        drain(r + 530);

        // 4: config read-back request during RUN
        pulse_start(32'd6, t);
        r = t + 164;
        ex(t, O_INIT, 32'd0, 16'd0);
        ex(t + 82, O_VER, 32'd0, 16'd0);
        ex(r, O_RUN, 32'd0, 16'd0);
        ex(r + 41, O_RUN, 32'd1, 16'd0);
`ifdef AD4003_READBACK_EN
        wexp = 16'h1402;
        ex(r + 82, O_RDBK, 32'd2, 16'd0);
        ex(r + 164, O_DONE, 32'd2, 16'h1402);
        ex(r + 165, O_RUN, 32'd2, 16'h1402);
        ex(r + 205, O_RUN, 32'd3, 16'h1402);
        ex(r + 246, O_RUN, 32'd4, 16'h1402);
        ex(r + 287, O_RUN, 32'd5, 16'h1402);
        ex(r + 328, O_DRAIN, 32'd6, 16'h1402);
        ex(r + 369, O_IDLE, 32'd6, 16'h1402);
`else
        ex(r + 82, O_RUN, 32'd2, 16'd0);
        ex(r + 123, O_RUN, 32'd3, 16'd0);
        ex(r + 164, O_RUN, 32'd4, 16'd0);
        ex(r + 205, O_RUN, 32'd5, 16'd0);
        ex(r + 246, O_DRAIN, 32'd6, 16'd0);
        ex(r + 287, O_IDLE, 32'd6, 16'd0);
`endif
        goto(t + 90);
        strobe(16'h0002);
        goto(r + 50);
        pulse_cfg();
        goto(r + 112);
        strobe(16'h1402);
        drain(r + 420);

        // 5: async reset mid-VERIFY, then restart and abort with stop in VERIFY
        pulse_start(32'd4, t);
        ex(t, O_INIT, 32'd0, wexp);
        ex(t + 82, O_VER, 32'd0, wexp);
        ex(0, O_IDLE, 32'd0, 16'd0);
        ex(41, O_INIT, 32'd0, 16'd0);
        ex(123, O_VER, 32'd0, 16'd0);
        ex(164, O_IDLE, 32'd0, 16'd0);
        goto(t + 100);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {des_rst, des_force_read, des_force_write, acq_active}, {4'b1000});
        repeat (3) @(negedge adc_spi_clk);
        #2 rst_n = 1'b1;
        goto(4);
        pulse_start(32'd4, t);
        chk("restart_boundary", 64'(t), 64'd41);
        goto(130);
        pulse_stop();
        drain(200);

        // 6: start and stop in the same IDLE frame -> stays IDLE
        goto(170);
        pulse_start(32'd4, t);
        goto(180);
        pulse_stop();
        goto(300);
        chk("start_stop_idle", {des_rst, des_force_read, des_force_write, acq_active, err}, {5'b10000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
